// File: rtl/alu_pkg.sv
// Shared types and constants for the sequential ALU and its control decoder.
package alu_pkg;

    typedef enum logic [3:0] {
        ADD  = 4'd0,
        SUB  = 4'd1,
        AND  = 4'd2,
        OR   = 4'd3,
        XOR  = 4'd4,
        SLT  = 4'd5,
        SLTU = 4'd6,
        SLL  = 4'd7,
        SRL  = 4'd8,
        SRA  = 4'd9,
        ILL  = 4'd10
    } alu_ctrl_t;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;
    localparam logic [1:0] ALUOP_ILL   = 2'b11;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    function automatic logic is_shift(input alu_ctrl_t ctrl);
        return (ctrl == SLL) || (ctrl == SRL) || (ctrl == SRA);
    endfunction

endpackage

// File: rtl/alu_ctrl_decode.sv
// Combinational ALU-control decoder: aluop/funct3/op5/funct7b5 to an operation code.
module alu_ctrl_decode
    import alu_pkg::*;
(
    input  logic [1:0] aluop,
    input  logic [2:0] funct3,
    input  logic       op5,
    input  logic       funct7b5,
    output alu_ctrl_t  ctrl
);

    always_comb begin
        ctrl = ILL;
        case (aluop)
            ALUOP_ADD: ctrl = ADD;
            ALUOP_SUB: ctrl = SUB;
            ALUOP_FUNCT: begin
                case (funct3)
                    3'b000:  ctrl = (op5 && funct7b5) ? SUB : ADD;
                    3'b001:  ctrl = SLL;
                    3'b010:  ctrl = SLT;
                    3'b011:  ctrl = SLTU;
                    3'b100:  ctrl = XOR;
                    3'b101:  ctrl = funct7b5 ? SRA : SRL;
                    3'b110:  ctrl = OR;
                    default: ctrl = AND;
                endcase
            end
            default: ctrl = ILL;
        endcase
    end

endmodule

// File: rtl/alu_seq.sv
// Registered RV32I-style ALU: single-cycle arithmetic/logic ops and
// bit-serial shifts behind a start/busy/done handshake.
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             nreset,
    input  logic             start,
    input  logic [1:0]       aluop,
    input  logic [2:0]       funct3,
    input  logic             op5,
    input  logic             funct7b5,
    input  logic [WIDTH-1:0] srca,
    input  logic [WIDTH-1:0] srcb,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             illegal
);

    localparam int SHAMT_W = $clog2(WIDTH);

    alu_ctrl_t dec_ctrl;

    alu_ctrl_decode u_decode (
        .aluop    (aluop),
        .funct3   (funct3),
        .op5      (op5),
        .funct7b5 (funct7b5),
        .ctrl     (dec_ctrl)
    );

    state_t             state_reg, state_next;
    alu_ctrl_t          ctrl_reg, ctrl_next;
    logic [WIDTH-1:0]   acc_reg, acc_next;
    logic [SHAMT_W-1:0] cnt_reg, cnt_next;
    logic [WIDTH-1:0]   result_reg, result_next;
    logic               illegal_reg, illegal_next;
    logic               done_reg, done_next;

    logic [WIDTH-1:0]   exec_result;
    logic [WIDTH-1:0]   shl1, shr1;
    logic               fill;

    // SRA keeps the MSB while shifting, so the accumulator's top bit is the original sign.
    assign fill = (ctrl_reg == SRA) & acc_reg[WIDTH-1];

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_shift1
            if (gi == 0) begin : g_lsb
                assign shl1[gi] = 1'b0;
            end else begin : g_lsb_n
                assign shl1[gi] = acc_reg[gi-1];
            end
            if (gi == WIDTH - 1) begin : g_msb
                assign shr1[gi] = fill;
            end else begin : g_msb_n
                assign shr1[gi] = acc_reg[gi+1];
            end
        end
    endgenerate

    always_comb begin
        exec_result = '0;
        case (dec_ctrl)
            ADD:     exec_result = srca + srcb;
            SUB:     exec_result = srca - srcb;
            AND:     exec_result = srca & srcb;
            OR:      exec_result = srca | srcb;
            XOR:     exec_result = srca ^ srcb;
            SLT:     exec_result[0] = $signed(srca) < $signed(srcb);
            SLTU:    exec_result[0] = srca < srcb;
            default: exec_result = '0;
        endcase
    end

    always_comb begin
        state_next   = state_reg;
        ctrl_next    = ctrl_reg;
        acc_next     = acc_reg;
        cnt_next     = cnt_reg;
        result_next  = result_reg;
        illegal_next = illegal_reg;
        done_next    = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    if (is_shift(dec_ctrl)) begin
                        ctrl_next  = dec_ctrl;
                        acc_next   = srca;
                        cnt_next   = srcb[SHAMT_W-1:0];
                        state_next = SHIFT;
                    end else begin
                        result_next  = exec_result;
                        illegal_next = (dec_ctrl == ILL);
                        done_next    = 1'b1;
                    end
                end
            end
            SHIFT: begin
                if (cnt_reg != '0) begin
                    acc_next = (ctrl_reg == SLL) ? shl1 : shr1;
                    cnt_next = cnt_reg - SHAMT_W'(1);
                end else begin
                    result_next  = acc_reg;
                    illegal_next = 1'b0;
                    done_next    = 1'b1;
                    state_next   = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!nreset) begin
            state_reg   <= IDLE;
            ctrl_reg    <= ADD;
            acc_reg     <= '0;
            cnt_reg     <= '0;
            result_reg  <= '0;
            illegal_reg <= 1'b0;
            done_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            ctrl_reg    <= ctrl_next;
            acc_reg     <= acc_next;
            cnt_reg     <= cnt_next;
            result_reg  <= result_next;
            illegal_reg <= illegal_next;
            done_reg    <= done_next;
        end
    end

    assign busy    = (state_reg != IDLE);
    assign done    = done_reg;
    assign result  = result_reg;
    assign illegal = illegal_reg;
    assign zero    = (result_reg == '0);

endmodule
